regfile_arbiter: RTL and testbench

Shares the single-port `register_file` (one address, one write-enable, registered read data) between two requesters: port A (operand fetch) and port B (writeback). Accepts at most one access per cycle with a round-robin policy and drives the register file directly. Returns each read result to its originating port a fixed latency later, tagged by a small in-flight pipeline. Sits between the control/decoder logic and the register file in the CPU datapath.

---
 rtl/regfile_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing a single-port register file between an operand-fetch
// port (A) and a writeback port (B), with a tagged in-flight pipeline for read returns.

module regfile_arbiter_stage (
  input  logic clk,
  input  logic reset,
  input  logic vld_in,
  input  logic id_in,
  output logic vld,
  output logic id
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= 1'b0;
      id  <= 1'b0;
    end else begin
      vld <= vld_in;
      id  <= id_in;
    end
  end
endmodule

module regfile_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_write,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_write,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_rsp_valid,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_address,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  input  logic [DATA_WIDTH-1:0] rf_read_data
);
  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  req_t req_a, req_b, win;
  logic prio;    // 0 = A has priority, 1 = B
  logic grant_a, grant_b, grant;

  assign req_a = {a_write, a_addr, a_wdata};
  assign req_b = {b_write, b_addr, b_wdata};

  // Gating with reset keeps every handshake and the rf write strobe quiet while held in reset.
  assign grant_a = reset & a_valid & (~b_valid | ~prio);
  assign grant_b = reset & b_valid & (~a_valid |  prio);
  assign grant   = grant_a | grant_b;
  assign win     = grant_b ? req_b : req_a;

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  assign rf_write_enable = grant & win.write;
  assign rf_address      = grant ? win.addr  : '0;
  assign rf_write_data   = grant ? win.wdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     prio <= 1'b0;
    else if (grant) prio <= grant_a;
  end

  // Index 0 is the tag of the access being granted now; index k is that tag k cycles later.
  logic [RD_LATENCY:0] vld_pipe;
  logic [RD_LATENCY:0] id_pipe;

  assign vld_pipe[0] = grant & ~win.write;
  assign id_pipe[0]  = grant_b;

  for (genvar k = 1; k <= RD_LATENCY; k++) begin : g_stage
    regfile_arbiter_stage u_stage (
      .clk    (clk),
      .reset  (reset),
      .vld_in (vld_pipe[k-1]),
      .id_in  (id_pipe[k-1]),
      .vld    (vld_pipe[k]),
      .id     (id_pipe[k])
    );
  end

  assign a_rsp_valid = reset & vld_pipe[RD_LATENCY] & ~id_pipe[RD_LATENCY];
  assign b_rsp_valid = reset & vld_pipe[RD_LATENCY] &  id_pipe[RD_LATENCY];
  assign rsp_rdata   = reset ? rf_read_data : '0;
endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: two instances (read latency 1 and 3) share one stimulus
// stream and are checked against a transaction-level model of grants, memory and returns.

module tb_regfile_arbiter;
  localparam int DW = 8;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a_valid = 1'b0, a_write = 1'b0, b_valid = 1'b0, b_write = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;

  logic [1:0]         a_ready, b_ready, a_rsp, b_rsp, rf_we;
  logic [1:0][DW-1:0] rsp_rdata, rf_wd, rf_rd;
  logic [1:0][AW-1:0] rf_addr;

  always #5 clk = ~clk;

  regfile_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready[0]), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready[0]), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_rsp_valid(a_rsp[0]), .b_rsp_valid(b_rsp[0]), .rsp_rdata(rsp_rdata[0]),
    .rf_write_enable(rf_we[0]), .rf_address(rf_addr[0]), .rf_write_data(rf_wd[0]),
    .rf_read_data(rf_rd[0])
  );

  regfile_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready[1]), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready[1]), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_rsp_valid(a_rsp[1]), .b_rsp_valid(b_rsp[1]), .rsp_rdata(rsp_rdata[1]),
    .rf_write_enable(rf_we[1]), .rf_address(rf_addr[1]), .rf_write_data(rf_wd[1]),
    .rf_read_data(rf_rd[1])
  );

  // Register files: registered read, extra output delay for the latency-3 instance.
  logic [DW-1:0] mem0 [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [DW-1:0] mem1 [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [DW-1:0] rd0 = '0, p0 = '0, p1 = '0, p2 = '0;

  always @(posedge clk) begin
    if (rf_we[0]) mem0[rf_addr[0]] <= rf_wd[0];
    rd0 <= mem0[rf_addr[0]];
  end
  always @(posedge clk) begin
    if (rf_we[1]) mem1[rf_addr[1]] <= rf_wd[1];
    p0 <= mem1[rf_addr[1]];
    p1 <= p0;
    p2 <= p1;
  end
  assign rf_rd[0] = rd0;
  assign rf_rd[1] = p2;

  // Reference model: priority bit, register contents, list of accepted reads.
  typedef struct {
    int            acc;
    bit            port;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          q[$];
  bit            m_prio = 1'b0;
  logic [DW-1:0] m_mem [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  bit            last_ga = 1'b0, last_gb = 1'b0;
  bit            dir_g_on = 1'b0, dir_r_on = 1'b0;
  logic [1:0]    dir_g = '0;
  bit            dir_r_port = 1'b0;
  logic [DW-1:0] dir_r_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, want);
    end
  endtask

  task automatic tick();
    logic ga, gb, ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd;
    @(negedge clk);
    ga = reset && a_valid && (!b_valid || !m_prio);
    gb = reset && b_valid && (!a_valid ||  m_prio);
    ewe   = ga ? a_write : gb ? b_write : 1'b0;
    eaddr = ga ? a_addr  : gb ? b_addr  : '0;
    ewd   = ga ? a_wdata : gb ? b_wdata : '0;
    for (int d = 0; d < 2; d++) begin
      int lat;
      logic ea, eb;
      logic [DW-1:0] ed;
      lat = (d == 0) ? 1 : 3;
      ea = 1'b0; eb = 1'b0; ed = '0;
      if (reset)
        foreach (q[i])
          if (q[i].acc + lat == cyc) begin
            ea = !q[i].port; eb = q[i].port; ed = q[i].data;
          end
      chk($sformatf("a_ready L%0d", lat), a_ready[d], ga);
      chk($sformatf("b_ready L%0d", lat), b_ready[d], gb);
      chk($sformatf("rf_we L%0d", lat), rf_we[d], ewe);
      chk($sformatf("rf_addr L%0d", lat), rf_addr[d], eaddr);
      chk($sformatf("rf_wdata L%0d", lat), rf_wd[d], ewd);
      chk($sformatf("a_rsp L%0d", lat), a_rsp[d], ea);
      chk($sformatf("b_rsp L%0d", lat), b_rsp[d], eb);
      if (ea || eb || !reset) chk($sformatf("rsp_rdata L%0d", lat), rsp_rdata[d], ed);
    end
    if (dir_g_on) chk("directed grant", {a_ready[0], b_ready[0]}, dir_g);
    if (dir_r_on) begin
      chk("directed rsp port", {a_rsp[0], b_rsp[0]}, dir_r_port ? 2'b01 : 2'b10);
      chk("directed rsp data", rsp_rdata[0], dir_r_data);
    end
    dir_g_on = 1'b0;
    dir_r_on = 1'b0;
    last_ga = ga;
    last_gb = gb;
    @(posedge clk);
    if (!reset) begin
      q.delete();
      m_prio = 1'b0;
    end else if (ga || gb) begin
      m_prio = ga;
      if (ewe) m_mem[eaddr] = ewd;
      else     q.push_back('{cyc, gb, m_mem[eaddr]});
    end
    cyc++;
    while (q.size() > 0 && q[0].acc + 3 < cyc) void'(q.pop_front());
    #1;
  endtask

  task automatic set_a(input logic v, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    a_valid = v; a_write = w; a_addr = ad; a_wdata = wd;
  endtask

  task automatic set_b(input logic v, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    b_valid = v; b_write = w; b_addr = ad; b_wdata = wd;
  endtask

  task automatic exp_g(input logic [1:0] g);
    dir_g_on = 1'b1; dir_g = g;
  endtask

  task automatic exp_r(input bit port, input logic [DW-1:0] data);
    dir_r_on = 1'b1; dir_r_port = port; dir_r_data = data;
  endtask

  initial begin
    // Reset held with both ports requesting.
    set_a(1, 0, 2'd0, '0);
    set_b(1, 0, 2'd3, '0);
    #1;
    exp_g(2'b00); tick();
    exp_g(2'b00); tick();
    reset = 1'b1;
    exp_g(2'b10); tick();
    set_a(0, 0, '0, '0);
    exp_g(2'b01); tick();
    set_b(0, 0, '0, '0);
    tick();

    // Single-port writes then reads.
    set_a(1, 1, 2'd0, 8'hA5); tick();
    set_a(1, 1, 2'd1, 8'h5A); tick();
    set_a(1, 1, 2'd2, 8'hFF); tick();
    set_a(1, 1, 2'd3, 8'h0F); tick();
    set_a(1, 0, 2'd0, '0); tick();
    set_a(1, 0, 2'd1, '0); exp_r(0, 8'hA5); tick();
    set_a(1, 0, 2'd2, '0); exp_r(0, 8'h5A); tick();
    set_a(1, 0, 2'd3, '0); exp_r(0, 8'hFF); tick();
    set_a(0, 0, '0, '0);   exp_r(0, 8'h0F); tick();

    // Single B read hands priority back to A, then contention.
    set_b(1, 0, 2'd3, '0); exp_g(2'b01); tick();
    set_a(1, 0, 2'd0, '0); exp_g(2'b10); exp_r(1, 8'h0F); tick();
    exp_g(2'b01); exp_r(0, 8'hA5); tick();
    exp_g(2'b10); exp_r(1, 8'h0F); tick();
    exp_g(2'b01); exp_r(0, 8'hA5); tick();
    set_a(0, 0, '0, '0); set_b(0, 0, '0, '0); exp_r(1, 8'h0F); tick();

    // A single A read leaves priority with B; B writes 2 while A reads 2.
    set_a(1, 0, 2'd1, '0); exp_g(2'b10); tick();
    set_b(1, 1, 2'd2, 8'h3C); set_a(1, 0, 2'd2, '0); exp_g(2'b01); exp_r(0, 8'h5A); tick();
    set_b(0, 0, '0, '0); exp_g(2'b10); tick();
    set_a(0, 0, '0, '0); exp_r(0, 8'h3C); tick();

    // Two reads in flight, then a one-cycle reset pulse.
    set_a(1, 0, 2'd0, '0); set_b(1, 0, 2'd1, '0); exp_g(2'b01); tick();
    exp_g(2'b10); tick();
    set_a(0, 0, '0, '0); set_b(0, 0, '0, '0); reset = 1'b0; tick();
    reset = 1'b1;
    set_a(1, 0, 2'd3, '0); set_b(1, 0, 2'd2, '0); exp_g(2'b10); tick();
    set_a(0, 0, '0, '0); exp_g(2'b01); tick();
    set_b(0, 0, '0, '0);
    repeat (4) tick();

    // Idle, then priority and register contents are intact.
    repeat (5) tick();
    set_a(1, 0, 2'd2, '0); set_b(1, 0, 2'd1, '0); exp_g(2'b10); tick();
    set_a(1, 0, 2'd0, '0); exp_g(2'b01); exp_r(0, 8'h3C); tick();
    set_b(1, 0, 2'd3, '0); exp_g(2'b10); exp_r(1, 8'h5A); tick();
    set_a(0, 0, '0, '0); exp_g(2'b01); exp_r(0, 8'hA5); tick();
    set_b(0, 0, '0, '0); exp_r(1, 8'h0F); tick();
    repeat (3) tick();

    // Random traffic with occasional reset; pending requests hold until accepted.
    for (int n = 0; n < 400; n++) begin
      if (!(a_valid && !last_ga))
        set_a($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, AW'($urandom), DW'($urandom));
      if (!(b_valid && !last_gb))
        set_b($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, AW'($urandom), DW'($urandom));
      reset = ($urandom_range(0, 39) != 0);
      tick();
    end
    reset = 1'b1;
    set_a(0, 0, '0, '0); set_b(0, 0, '0, '0);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
